// File: rtl/led_pattern_sched.sv
// rtl/led_pattern_sched.sv - tick time-base and LED pattern scheduler (off/flash/run/bounce)
module led_pattern_sched #(
    parameter int T_TICK = 2_499_999,
    parameter int CNT_W  = 22,
    parameter int N_LED  = 4
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Mode_Req,
    input  logic [1:0]       Mode_Sel,
    input  logic             Hold,
    output logic [N_LED-1:0] LED_Out,
    output logic [1:0]       Mode_Cur,
    output logic             Pending,
    output logic             Tick_Out
);

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_FLASH  = 2'd1;
    localparam logic [1:0] MODE_RUN    = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam logic [CNT_W-1:0] TERM     = CNT_W'(T_TICK);
    localparam logic [N_LED-1:0] LED_LSB  = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] LED_ALL  = {N_LED{1'b1}};
    localparam logic [N_LED-1:0] LED_NONE = {N_LED{1'b0}};

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             tick_edge;
    logic [1:0]       pend_mode;
    logic             dir_up;
    logic             dir_up_nxt;
    logic [N_LED-1:0] led_nxt;
    logic [1:0]       mode_nxt;

    // Tick edge: terminal count reached while not held; Hold freezes the counter in place.
    always_comb begin
        tick_edge = !Hold && (count == TERM);
        if (Hold)
            count_nxt = count;
        else if (tick_edge)
            count_nxt = '0;
        else
            count_nxt = count + 1'b1;
    end

    // Next pattern: a pending request wins over advancing; RUN/BOUNCE recover to LSB if ever blank.
    always_comb begin
        led_nxt    = LED_Out;
        mode_nxt   = Mode_Cur;
        dir_up_nxt = dir_up;
        if (tick_edge) begin
            if (Pending) begin
                mode_nxt   = pend_mode;
                dir_up_nxt = 1'b1;
                case (pend_mode)
                    MODE_OFF:   led_nxt = LED_NONE;
                    MODE_FLASH: led_nxt = LED_ALL;
                    default:    led_nxt = LED_LSB;
                endcase
            end else begin
                case (Mode_Cur)
                    MODE_OFF:   led_nxt = LED_NONE;
                    MODE_FLASH: led_nxt = ~LED_Out;
                    MODE_RUN: begin
                        if (LED_Out == LED_NONE)
                            led_nxt = LED_LSB;
                        else
                            led_nxt = {LED_Out[N_LED-2:0], LED_Out[N_LED-1]};
                    end
                    MODE_BOUNCE: begin
                        if (LED_Out == LED_NONE) begin
                            led_nxt    = LED_LSB;
                            dir_up_nxt = 1'b1;
                        end else if (dir_up) begin
                            led_nxt = LED_Out << 1;
                            if (led_nxt[N_LED-1])
                                dir_up_nxt = 1'b0;
                        end else begin
                            led_nxt = LED_Out >> 1;
                            if (led_nxt[0])
                                dir_up_nxt = 1'b1;
                        end
                    end
                    default:    led_nxt = LED_NONE;
                endcase
            end
        end
    end

    // State register: counter, pattern, direction and request latch; a same-cycle request re-arms Pending.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            count     <= '0;
            LED_Out   <= LED_NONE;
            Mode_Cur  <= MODE_OFF;
            Pending   <= 1'b0;
            pend_mode <= MODE_OFF;
            dir_up    <= 1'b1;
            Tick_Out  <= 1'b0;
        end else begin
            count    <= count_nxt;
            LED_Out  <= led_nxt;
            Mode_Cur <= mode_nxt;
            dir_up   <= dir_up_nxt;
            Tick_Out <= tick_edge;
            if (Mode_Req) begin
                pend_mode <= Mode_Sel;
                Pending   <= 1'b1;
            end else if (tick_edge) begin
                Pending   <= 1'b0;
            end
        end
    end

endmodule
